// File: rtl/de1soc_io_pkg.sv
// ---------------------------------------------------------------------------
// de1soc_io_pkg
// Shared constants for the DE1-SoC board I/O conditioning blocks.
//   CLK_HZ                  : board system clock (CLOCK_50)
//   DEBOUNCE_MS             : pushbutton settle time
//   DEBOUNCE_CYCLES_DEFAULT : settle time expressed in CLK_HZ cycles
// ---------------------------------------------------------------------------
package de1soc_io_pkg;

  localparam int unsigned CLK_HZ                  = 50_000_000;
  localparam int unsigned DEBOUNCE_MS             = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage : de1soc_io_pkg

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One pushbutton channel: 2-flop synchronizer on the raw active-low pin,
// consecutive-sample debounce counter and registered press/release pulses.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   key_n        : raw asynchronous pin, active-low
//   key_pressed  : debounced level, 1 = held
//   key_press    : one-cycle pulse in the first cycle key_pressed reads 1
//   key_release  : one-cycle pulse in the first cycle key_pressed reads 0
//   press_next   : combinational "key_press will be 1 next cycle", lets the
//                  parent load data registers in step with key_press
// ---------------------------------------------------------------------------
module key_debounce
  import de1soc_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_pressed,
  output logic key_press,
  output logic key_release,
  output logic press_next
);

  localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_sync;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // sync_q[1] is the metastability-safe stage; invert to active-high.
  assign key_sync = ~sync_q[1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (key_sync == stable_q) begin
      // Any sample agreeing with the accepted level restarts the count.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Counter never passes CNT_MAX: it resets here instead of wrapping.
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d   =  stable_d & ~stable_q;
    release_d = ~stable_d &  stable_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    if (reset) begin
      sync_q    <= 2'b11;   // released pin level
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_pressed = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  // Gated by reset so the parent never sees a load request during reset.
  assign press_next  = press_d & ~reset;

endmodule : key_debounce

// File: rtl/de1soc_key_input.sv
// ---------------------------------------------------------------------------
// de1soc_key_input
// DE1-SoC pushbutton and slider-switch input conditioner. Each KEY pin gets
// its own debounce channel; the synchronized SW value is captured on every
// debounced KEY[0] press.
// Ports:
//   clk, reset   : 50 MHz system clock, synchronous active-high reset
//   key_n        : raw KEY pins, asynchronous, active-low
//   sw           : raw SW pins, asynchronous
//   key_pressed  : debounced levels, 1 = held
//   key_press    : one-cycle pulse per debounced press
//   key_release  : one-cycle pulse per debounced release
//   sw_value     : SW value captured on the KEY[0] press
//   sw_valid     : one-cycle pulse in the cycle sw_value updates
// ---------------------------------------------------------------------------
module de1soc_key_input
  import de1soc_io_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_SW-1:0]   sw_value,
  output logic                sw_valid
);

  // Keys whose press captures SW; only KEY[0] does.
  localparam logic [NUM_KEYS-1:0] SW_LOAD_KEYS = NUM_KEYS'(1);

  logic [NUM_KEYS-1:0] press_next;
  logic                sw_load;
  logic [NUM_SW-1:0]   sw_meta_q, sw_sync_q;
  logic [NUM_SW-1:0]   sw_value_q, sw_value_d;
  logic                sw_valid_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk         (clk),
      .reset       (reset),
      .key_n       (key_n[i]),
      .key_pressed (key_pressed[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .press_next  (press_next[i])
    );
  end

  // Load on the same edge that raises key_press[0], so sw_value and
  // sw_valid change in the cycle the press pulse is visible.
  assign sw_load    = |(press_next & SW_LOAD_KEYS);
  assign sw_value_d = sw_load ? sw_sync_q : sw_value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sw_value_q <= '0;
      sw_valid_q <= 1'b0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      sw_value_q <= sw_value_d;
      sw_valid_q <= sw_load;
    end
  end

  assign sw_value = sw_value_q;
  assign sw_valid = sw_valid_q;

endmodule : de1soc_key_input

// File: doc/de1soc_key_input.md
# de1soc_key_input

Debounced pushbutton and slider-switch input conditioner for the DE1-SoC board. It takes the raw, asynchronous, active-low `KEY` pins, synchronizes and debounces each one, and produces clean active-high levels plus one-cycle press/release pulses. It also latches the `SW` value on each debounced `KEY[0]` press, which gives the input-side counterpart to the hex display output path. It is instantiated in the board top level, between the pins and the NIOS system and hex-display logic.

## Interface
- `NUM_KEYS`, default 4: number of pushbuttons conditioned.
- `NUM_SW`, default 10: slider switch width.
- `DEBOUNCE_CYCLES`, default 1_000_000: required consecutive stable synchronized samples before a level change is accepted (20 ms at 50 MHz). Legal range ≥ 2.

Ports:
- `clk`  in  1  system clock, 50 MHz (`CLOCK_50` at top).
- `reset`  in  1  synchronous, active-high reset.
- `key_n`  in  NUM_KEYS  raw `KEY` pins; asynchronous; active-low.
- `sw`  in  NUM_SW  raw `SW` pins; asynchronous.
- `key_pressed`  out  NUM_KEYS  debounced level; 1 = held.
- `key_press`  out  NUM_KEYS  one-cycle pulse on each debounced press.
- `key_release`  out  NUM_KEYS  one-cycle pulse on each debounced release.
- `sw_value`  out  NUM_SW  `SW` value captured on the `KEY[0]` press.
- `sw_valid`  out  1  one-cycle pulse when `sw_value` updates.

## Operation
- Each key uses a 2-flop synchronizer on `key_n`, then inverts the result to form `key_sync` (active-high).
- Per-key debounce state has two parts: `stable` (the `key_pressed` bit) and counter `cnt`, of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `key_sync == stable`, `cnt` is set to 0.
  - If `key_sync != stable` and `cnt == DEBOUNCE_CYCLES-1`, `stable` toggles and `cnt` is set to 0.
  - Otherwise, `cnt` increments.
- Any sample that matches `stable` restarts the count, so bounces shorter than `DEBOUNCE_CYCLES` samples are ignored.
- `key_press[i]` is 1 in exactly the cycle `key_pressed[i]` first reads 1. `key_release[i]` is 1 in exactly the cycle it first reads 0.
- `sw` passes through its own 2-flop synchronizer. In the cycle `key_press[0]` is 1, the synchronized `sw` is loaded into `sw_value` and `sw_valid` is 1 in the same cycle. No other key loads `sw_value`.
- Keys are fully independent. Simultaneous events on several keys produce simultaneous pulses.
- `cnt` saturates logically: it never exceeds `DEBOUNCE_CYCLES-1`, and it never wraps.

## Timing
- Reset values:
  - All synchronizer flops are set to the released state (`key_n` sync = 1, `sw` sync = 0).
  - `stable`, `cnt`, `key_pressed`, `key_press`, `key_release`, `sw_value` and `sw_valid` are all 0.
- Latency: a pin level held from clock edge t is visible on `key_pressed` at edge t+2+DEBOUNCE_CYCLES. That is 2 cycles of synchronizer plus `DEBOUNCE_CYCLES` samples.
- Pulses are registered and last exactly 1 cycle. A press and a release of the same key are never in the same cycle.
- If reset is asserted mid-count, all state returns to reset values on that edge. Counting restarts from 0 after deassertion. A key still held is recognised 2+DEBOUNCE_CYCLES cycles after the first non-reset edge.
- Pulses are not emitted at reset deassertion, because `stable` starts at 0 regardless of pin state.

## Structure
- Shared package `de1soc_io_pkg` holds:
  - `CLK_HZ` = 50_000_000.
  - `DEBOUNCE_MS` = 20.
  - Derived constant `DEBOUNCE_CYCLES_DEFAULT`.
- Sub-module `key_debounce`: one channel containing the synchronizer, counter, `stable`, and the press/release pulses. It is instantiated `NUM_KEYS` times via generate.
- The `sw` synchronizer and capture register live in the top of this block.

## Test plan
Simulate with `DEBOUNCE_CYCLES` = 8.
- Reset: hold `reset` for 3 cycles with `key_n` = 4'b0000 and `sw` = 10'h3FF → all outputs are 0 during reset and in the first cycle after.
- Clean press: `key_n[0]` = 0 from edge 10, `sw` = 10'h2A5 held → `key_pressed[0]` rises at edge 20. `key_press[0]` and `sw_valid` are each high for 1 cycle, and `sw_value` = 10'h2A5.
- Bounce: `key_n[1]` repeats low 5 cycles / high 2 cycles 4 times, then stays high → `key_pressed[1]` stays 0 and no pulses are emitted. Holding it low afterwards → press is recognised 10 cycles later.
- Release: `key_n[0]` goes high after a recognised press → `key_release[0]` pulses 10 cycles later. `sw_valid` stays 0 and `sw_value` is unchanged.
- Simultaneous keys: `key_n[1]` and `key_n[3]` go low on the same edge → `key_press` = 4'b1010 for exactly 1 cycle, 10 cycles later, with no `sw_valid`.
- Reset mid-operation: `key_n[2]` is low, and `reset` is asserted when `cnt` = 5 → nothing is recognised. The press is recognised 10 cycles after reset deassertion.
